// File: rtl/l1_load_miss_queue.sv
// ---------------------------------------------------------------------------
// l1_load_miss_queue
//
// Purpose:
//    Holds the outstanding L1 data-cache load misses between the tag lookup
//    and the L2 request interface. Misses to the same line from different
//    strands share one entry. Each unique line is sent to L2 once, using a
//    valid/ready handshake. When L2 returns the fill, this block writes the
//    tag update (way, tag, set) and pulses a wake-up mask for every strand
//    that was waiting on that line.
//
// Ports:
//    clk                      rising-edge clock
//    reset                    synchronous, active-high reset
//    request_i                load miss this cycle
//    request_addr             26-bit line address (set in low bits, tag above)
//    request_way              victim way for the fill
//    request_strand           strand that missed
//    l2_req_valid_o           L2 fill request valid
//    l2_req_ready_i           L2 accepts the request this cycle
//    l2_req_addr_o            line address of the request
//    l2_req_way_o             victim way of the request
//    l2_req_id_o              entry index, echoed back by L2
//    l2_rsp_valid_i           fill complete for entry l2_rsp_id_i
//    l2_rsp_id_i              entry being completed
//    update_o                 tag/valid write strobe (one cycle after response)
//    update_way_o             way to write
//    update_tag_o             tag to write
//    update_set_o             set to write
//    load_complete_strands_o  one-cycle wake-up mask of strands
// ---------------------------------------------------------------------------

`ifndef L1_SET_INDEX_WIDTH
`define L1_SET_INDEX_WIDTH 6
`endif

`ifndef L1_TAG_WIDTH
`define L1_TAG_WIDTH (26 - `L1_SET_INDEX_WIDTH)
`endif

module l1_load_miss_queue #(
   parameter int NUM_ENTRIES = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             request_i,
   input  logic [25:0]                      request_addr,
   input  logic [1:0]                       request_way,
   input  logic [$clog2(NUM_ENTRIES)-1:0]   request_strand,
   output logic                             l2_req_valid_o,
   input  logic                             l2_req_ready_i,
   output logic [25:0]                      l2_req_addr_o,
   output logic [1:0]                       l2_req_way_o,
   output logic [$clog2(NUM_ENTRIES)-1:0]   l2_req_id_o,
   input  logic                             l2_rsp_valid_i,
   input  logic [$clog2(NUM_ENTRIES)-1:0]   l2_rsp_id_i,
   output logic                             update_o,
   output logic [1:0]                       update_way_o,
   output logic [`L1_TAG_WIDTH-1:0]         update_tag_o,
   output logic [`L1_SET_INDEX_WIDTH-1:0]   update_set_o,
   output logic [NUM_ENTRIES-1:0]           load_complete_strands_o
);

   localparam int IDW  = $clog2(NUM_ENTRIES);
   localparam int SETW = `L1_SET_INDEX_WIDTH;

   typedef enum logic [1:0] {
      FREE    = 2'd0,
      PENDING = 2'd1,
      ISSUED  = 2'd2
   } entry_state_t;

   entry_state_t            state_q   [NUM_ENTRIES];
   logic [25:0]             addr_q    [NUM_ENTRIES];
   logic [1:0]              way_q     [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0]  waiting_q [NUM_ENTRIES];

   logic [IDW-1:0]          issue_ptr_q;
   logic                    locked_q;
   logic [IDW-1:0]          locked_id_q;

   logic                    update_q;
   logic [1:0]              update_way_q;
   logic [25:0]             update_addr_q;
   logic [NUM_ENTRIES-1:0]  complete_mask_q;

   logic [NUM_ENTRIES-1:0]  strand_onehot;
   logic [NUM_ENTRIES-1:0]  pending_vec;
   logic                    match_found;
   logic [IDW-1:0]          match_idx;
   logic                    free_found;
   logic [IDW-1:0]          free_idx;
   logic                    rr_found;
   logic [IDW-1:0]          rr_idx;
   logic [IDW-1:0]          rr_cand;
   logic                    issue_valid;
   logic [IDW-1:0]          sel_idx;
   logic                    issue_fire;
   logic [IDW-1:0]          next_issue_ptr;
   logic                    merge_hit;
   logic                    alloc_hit;
   logic                    retire_merge;

   // Decode the requesting strand into a one-hot bit and collect which
   // entries are waiting to be sent to L2.
   always_comb begin
      strand_onehot = '0;
      strand_onehot[request_strand] = 1'b1;
      pending_vec = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         pending_vec[i] = (state_q[i] == PENDING);
      end
   end

   // Look for a live entry that already tracks this line. A live entry can
   // be PENDING or ISSUED. An entry retiring this cycle still counts as a
   // match, so a strand that misses on it joins the wake-up that is leaving.
   always_comb begin
      match_found = 1'b0;
      match_idx   = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (!match_found && state_q[i] != FREE && addr_q[i] == request_addr) begin
            match_found = 1'b1;
            match_idx   = IDW'(i);
         end
      end
   end

   // Find the lowest-index free entry for allocation. An entry freed by a
   // response in this cycle becomes visible here only in the next cycle.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (!free_found && state_q[i] == FREE) begin
            free_found = 1'b1;
            free_idx   = IDW'(i);
         end
      end
   end

   // Round-robin search for a PENDING entry, starting at issue_ptr and
   // wrapping around the entry array.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      rr_cand  = '0;
      for (int k = 0; k < NUM_ENTRIES; k++) begin
         rr_cand = IDW'((int'(issue_ptr_q) + k) % NUM_ENTRIES);
         if (!rr_found && pending_vec[rr_cand]) begin
            rr_found = 1'b1;
            rr_idx   = rr_cand;
         end
      end
   end

   // The L2 request depends only on registered state. Once a request has
   // been shown and stalled, the locked index keeps it stable. Without the
   // lock, a newly allocated entry could win the round-robin search and
   // change the request while it is stalled. Outputs read zero when idle.
   always_comb begin
      issue_valid    = |pending_vec;
      sel_idx        = locked_q ? locked_id_q : rr_idx;
      issue_fire     = issue_valid && l2_req_ready_i;
      next_issue_ptr = (sel_idx == IDW'(NUM_ENTRIES - 1)) ? '0 : sel_idx + 1'b1;

      l2_req_valid_o = issue_valid;
      l2_req_addr_o  = issue_valid ? addr_q[sel_idx] : '0;
      l2_req_way_o   = issue_valid ? way_q[sel_idx]  : '0;
      l2_req_id_o    = issue_valid ? sel_idx         : '0;

      merge_hit    = request_i && match_found;
      alloc_hit    = request_i && !match_found && free_found;
      retire_merge = merge_hit && l2_rsp_valid_i && (match_idx == l2_rsp_id_i);
   end

   // Per-entry state update. A response frees its entry and clears its
   // mask, and it wins over a merge into the same entry. That merged strand
   // is woken through the registered response mask below. Acceptance and
   // response always hit different entries, because only ISSUED entries are
   // completed and only PENDING entries are accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            state_q[i]   <= FREE;
            addr_q[i]    <= '0;
            way_q[i]     <= '0;
            waiting_q[i] <= '0;
         end
         issue_ptr_q <= '0;
         locked_q    <= 1'b0;
         locked_id_q <= '0;
      end else begin
         locked_q    <= issue_valid && !l2_req_ready_i;
         locked_id_q <= sel_idx;
         if (issue_fire) begin
            issue_ptr_q <= next_issue_ptr;
         end
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (l2_rsp_valid_i && l2_rsp_id_i == IDW'(i)) begin
               state_q[i]   <= FREE;
               waiting_q[i] <= '0;
            end else begin
               if (issue_fire && sel_idx == IDW'(i)) begin
                  state_q[i] <= ISSUED;
               end
               if (alloc_hit && free_idx == IDW'(i)) begin
                  state_q[i]   <= PENDING;
                  addr_q[i]    <= request_addr;
                  way_q[i]     <= request_way;
                  waiting_q[i] <= strand_onehot;
               end
               if (merge_hit && match_idx == IDW'(i)) begin
                  waiting_q[i] <= waiting_q[i] | strand_onehot;
               end
            end
         end
      end
   end

   // Register the tag update and wake-up pulse one cycle after the
   // response. A strand that merges into the retiring entry in the same
   // cycle is added to the pulse here.
   always_ff @(posedge clk) begin
      if (reset) begin
         update_q        <= 1'b0;
         update_way_q    <= '0;
         update_addr_q   <= '0;
         complete_mask_q <= '0;
      end else if (l2_rsp_valid_i) begin
         update_q        <= 1'b1;
         update_way_q    <= way_q[l2_rsp_id_i];
         update_addr_q   <= addr_q[l2_rsp_id_i];
         complete_mask_q <= waiting_q[l2_rsp_id_i] |
                            (retire_merge ? strand_onehot : '0);
      end else begin
         update_q        <= 1'b0;
         update_way_q    <= '0;
         update_addr_q   <= '0;
         complete_mask_q <= '0;
      end
   end

   // Split the registered line address into the tag and set fields that
   // the tag memory write needs.
   always_comb begin
      update_o                = update_q;
      update_way_o            = update_way_q;
      update_tag_o            = update_addr_q[25:SETW];
      update_set_o            = update_addr_q[SETW-1:0];
      load_complete_strands_o = complete_mask_q;
   end

`ifndef SYNTHESIS
   logic strand_busy;

   // A strand is busy when some live entry already lists it as waiting.
   always_comb begin
      strand_busy = 1'b0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (state_q[i] != FREE && waiting_q[i][request_strand]) begin
            strand_busy = 1'b1;
         end
      end
   end

   // Catch protocol misuse. A strand may have only one outstanding miss,
   // the queue must have room for a new line, and L2 may only complete
   // entries it was actually sent.
   always @(posedge clk) begin
      if (!reset) begin
         if (request_i) begin
            assert (!strand_busy)
               else $error("strand %0d already has an outstanding miss", request_strand);
            assert (match_found || free_found)
               else $error("miss with no matching and no free entry");
         end
         if (l2_rsp_valid_i) begin
            assert (state_q[l2_rsp_id_i] == ISSUED)
               else $error("response for entry %0d that is not issued", l2_rsp_id_i);
         end
      end
   end
`endif

endmodule

// File: tb/tb_l1_load_miss_queue.sv
// ---------------------------------------------------------------------------
// tb_l1_load_miss_queue
//
// Purpose:
//    Directed bench for l1_load_miss_queue. Expected values are worked out
//    by hand from a 6-bit set index and a 20-bit tag.
// ---------------------------------------------------------------------------

module tb_l1_load_miss_queue;

   logic        clk;
   logic        reset;
   logic        request_i;
   logic [25:0] request_addr;
   logic [1:0]  request_way;
   logic [1:0]  request_strand;
   logic        l2_req_valid_o;
   logic        l2_req_ready_i;
   logic [25:0] l2_req_addr_o;
   logic [1:0]  l2_req_way_o;
   logic [1:0]  l2_req_id_o;
   logic        l2_rsp_valid_i;
   logic [1:0]  l2_rsp_id_i;
   logic        update_o;
   logic [1:0]  update_way_o;
   logic [19:0] update_tag_o;
   logic [5:0]  update_set_o;
   logic [3:0]  load_complete_strands_o;

   int checkCount;
   int failCount;

   l1_load_miss_queue #(.NUM_ENTRIES(4)) dut (
      .clk                     (clk),
      .reset                   (reset),
      .request_i               (request_i),
      .request_addr            (request_addr),
      .request_way             (request_way),
      .request_strand          (request_strand),
      .l2_req_valid_o          (l2_req_valid_o),
      .l2_req_ready_i          (l2_req_ready_i),
      .l2_req_addr_o           (l2_req_addr_o),
      .l2_req_way_o            (l2_req_way_o),
      .l2_req_id_o             (l2_req_id_o),
      .l2_rsp_valid_i          (l2_rsp_valid_i),
      .l2_rsp_id_i             (l2_rsp_id_i),
      .update_o                (update_o),
      .update_way_o            (update_way_o),
      .update_tag_o            (update_tag_o),
      .update_set_o            (update_set_o),
      .load_complete_strands_o (load_complete_strands_o)
   );

   // Free-running clock with a 10-time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive every DUT input for the coming clock edge.
   task automatic applyStimulus(input logic req, input logic [25:0] addr,
                                input logic [1:0] way, input logic [1:0] strand,
                                input logic ready, input logic rspValid,
                                input logic [1:0] rspId);
      request_i      = req;
      request_addr   = addr;
      request_way    = way;
      request_strand = strand;
      l2_req_ready_i = ready;
      l2_rsp_valid_i = rspValid;
      l2_rsp_id_i    = rspId;
   endtask

   // Advance one clock and settle just past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count one comparison and report it if the values differ.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Check the L2 request outputs. When no request is expected, only
   // valid is compared.
   task automatic checkReq(input string tag, input logic valid,
                           input logic [25:0] addr, input logic [1:0] way,
                           input logic [1:0] id);
      checkOutput({tag, "_valid"}, 32'(l2_req_valid_o), 32'(valid));
      if (valid) begin
         checkOutput({tag, "_addr"}, 32'(l2_req_addr_o), 32'(addr));
         checkOutput({tag, "_way"},  32'(l2_req_way_o),  32'(way));
         checkOutput({tag, "_id"},   32'(l2_req_id_o),   32'(id));
      end
   endtask

   // Check the registered fill-update outputs and the wake-up mask.
   task automatic checkUpdate(input string tag, input logic upd,
                              input logic [1:0] way, input logic [25:0] addr,
                              input logic [3:0] mask);
      logic [19:0] expTag;
      logic [5:0]  expSet;
      expTag = addr[25:6];
      expSet = addr[5:0];
      checkOutput({tag, "_update"}, 32'(update_o), 32'(upd));
      checkOutput({tag, "_mask"},   32'(load_complete_strands_o), 32'(mask));
      if (upd) begin
         checkOutput({tag, "_uway"}, 32'(update_way_o), 32'(way));
         checkOutput({tag, "_utag"}, 32'(update_tag_o), 32'(expTag));
         checkOutput({tag, "_uset"}, 32'(update_set_o), 32'(expSet));
      end
   endtask

   localparam logic [25:0] ADDR_T2 = 26'h0001234;
   localparam logic [25:0] ADDR_X  = 26'h0ABCDC0;
   localparam logic [25:0] ADDR_A  = 26'h0100040;
   localparam logic [25:0] ADDR_B  = 26'h0200081;
   localparam logic [25:0] ADDR_C  = 26'h03000C2;
   localparam logic [25:0] ADDR_D  = 26'h0400103;
   localparam logic [25:0] ADDR_E  = 26'h1555555;
   localparam logic [25:0] ADDR_F  = 26'h0F0F0F0;
   localparam logic [25:0] ADDR_G  = 26'h00000FF;
   localparam logic [25:0] ADDR_H  = 26'h3FFFFFF;

   initial begin
      logic [25:0] addrs [4];
      checkCount = 0;
      failCount  = 0;
      addrs[0] = ADDR_A;
      addrs[1] = ADDR_B;
      addrs[2] = ADDR_C;
      addrs[3] = ADDR_D;

      // Reset, then stay idle.
      reset = 1'b1;
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checkReq("idle", 1'b0, '0, '0, '0);
         checkUpdate("idle", 1'b0, '0, '0, 4'b0000);
         tick();
      end

      // Single miss, then fill. The tag is 0x48 and the set is 0x34.
      applyStimulus(1'b1, ADDR_T2, 2'd2, 2'd1, 1'b1, 1'b0, '0);
      tick();
      checkReq("single_req", 1'b1, ADDR_T2, 2'd2, 2'd0);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
      tick();
      checkReq("single_after_accept", 1'b0, '0, '0, '0);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b1, 2'd0);
      checkUpdate("single_pre_update", 1'b0, '0, '0, 4'b0000);
      tick();
      checkOutput("single_tag_const", 32'(update_tag_o), 32'h48);
      checkOutput("single_set_const", 32'(update_set_o), 32'h34);
      checkUpdate("single_update", 1'b1, 2'd2, ADDR_T2, 4'b0010);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
      tick();
      checkUpdate("single_pulse_end", 1'b0, '0, '0, 4'b0000);

      // Two strands miss on the same line and share one L2 request.
      applyStimulus(1'b1, ADDR_X, 2'd1, 2'd0, 1'b0, 1'b0, '0);
      tick();
      checkReq("merge_req0", 1'b1, ADDR_X, 2'd1, 2'd0);
      applyStimulus(1'b1, ADDR_X, 2'd3, 2'd3, 1'b0, 1'b0, '0);
      tick();
      checkReq("merge_req1", 1'b1, ADDR_X, 2'd1, 2'd0);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
      tick();
      checkReq("merge_one_request", 1'b0, '0, '0, '0);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b1, 2'd0);
      tick();
      checkUpdate("merge_update", 1'b1, 2'd1, ADDR_X, 4'b1001);
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
      tick();

      // Four distinct misses while L2 stalls, then round-robin issue.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, addrs[i], 2'(i), 2'(i), 1'b0, 1'b0, '0);
         tick();
         checkReq("stall_hold", 1'b1, ADDR_A, 2'd0, 2'd0);
      end
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
      tick();
      checkReq("stall_hold5", 1'b1, ADDR_A, 2'd0, 2'd0);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
      for (int i = 0; i < 4; i++) begin
         checkReq("rr_issue", 1'b1, addrs[i], 2'(i), 2'(i));
         tick();
      end
      checkReq("rr_drained", 1'b0, '0, '0, '0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b1, 2'(i));
         tick();
         checkUpdate("rr_update", 1'b1, 2'(i), addrs[i], 4'(1 << i));
      end
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
      tick();
      checkUpdate("rr_quiet", 1'b0, '0, '0, 4'b0000);

      // A miss on the line being retired joins that retirement's wake-up.
      applyStimulus(1'b1, ADDR_E, 2'd3, 2'd0, 1'b1, 1'b0, '0);
      tick();
      checkReq("retire_req", 1'b1, ADDR_E, 2'd3, 2'd0);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
      tick();
      applyStimulus(1'b1, ADDR_E, 2'd1, 2'd2, 1'b1, 1'b1, 2'd0);
      tick();
      checkUpdate("retire_merge", 1'b1, 2'd3, ADDR_E, 4'b0101);
      checkReq("retire_no_new", 1'b0, '0, '0, '0);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
      tick();
      checkUpdate("retire_single_pulse", 1'b0, '0, '0, 4'b0000);
      checkReq("retire_still_idle", 1'b0, '0, '0, '0);

      // A miss on the same line one cycle after the response allocates a
      // new entry.
      applyStimulus(1'b1, ADDR_E, 2'd3, 2'd0, 1'b1, 1'b0, '0);
      tick();
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
      tick();
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b1, 2'd0);
      tick();
      checkUpdate("late_update", 1'b1, 2'd3, ADDR_E, 4'b0001);
      applyStimulus(1'b1, ADDR_E, 2'd1, 2'd2, 1'b1, 1'b0, '0);
      tick();
      checkReq("late_realloc", 1'b1, ADDR_E, 2'd1, 2'd0);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
      tick();
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b1, 2'd0);
      tick();
      checkUpdate("late_fill", 1'b1, 2'd1, ADDR_E, 4'b0100);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
      tick();

      // Reset while two entries are issued, then allocate from entry 0.
      applyStimulus(1'b1, ADDR_F, 2'd2, 2'd0, 1'b1, 1'b0, '0);
      tick();
      checkReq("flight_req0", 1'b1, ADDR_F, 2'd2, 2'd0);
      applyStimulus(1'b1, ADDR_G, 2'd0, 2'd1, 1'b1, 1'b0, '0);
      tick();
      checkReq("flight_req1", 1'b1, ADDR_G, 2'd0, 2'd1);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
      tick();
      checkReq("flight_issued", 1'b0, '0, '0, '0);
      reset = 1'b1;
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1, 2'd0);
      tick();
      reset = 1'b0;
      checkReq("reset_req", 1'b0, '0, '0, '0);
      checkOutput("reset_addr", 32'(l2_req_addr_o), 32'h0);
      checkUpdate("reset_update", 1'b0, '0, '0, 4'b0000);
      applyStimulus(1'b1, ADDR_H, 2'd1, 2'd3, 1'b0, 1'b0, '0);
      tick();
      checkReq("reset_realloc", 1'b1, ADDR_H, 2'd1, 2'd0);
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
